serializer: RTL

- Downstream neighbour of the deserializer: accepts one parallel frame of N_SAMPLES words (the deserializer's send side) and emits the words one per handshake, index 0 first.
- Used where a vector-wide stage (e.g. FFT or classifier) must hand samples back to a word-serial link (SPI/FIFO side).
- Uses val/rdy handshakes on both sides. A transfer occurs on any rising clk edge where val and rdy are both 1.

---
 rtl/serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//
// Purpose:
//    Accepts one parallel frame of N_SAMPLES words over a val/rdy handshake.
//    Emits the words one per val/rdy handshake, word 0 first. This block sits
//    downstream of a vector-wide stage and feeds a word-serial link.
//
// Parameters:
//    N_SAMPLES  words per frame (at least 2; does not need to be a power of two)
//    BIT_WIDTH  bits per word
//
// Ports:
//    clk        system clock, rising edge
//    reset      synchronous, active-low reset
//    recv_val   upstream frame valid
//    recv_rdy   serializer can accept a frame
//    recv_msg   parallel frame, element i is word i
//    send_val   serial word valid
//    send_rdy   downstream can accept a word
//    send_msg   current serial word
//    send_last  high while send_msg carries word N_SAMPLES-1
//
// Optional feature:
//    SERIALIZER_BACK_TO_BACK_EN - when defined, a new frame can be accepted on
//    the same edge that hands off the last word of the current frame. Frames
//    then stream with no idle bubble between them.
// -----------------------------------------------------------------------------
module serializer #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic                 send_last
);

    localparam int IDX_W = (N_SAMPLES > 2) ? $clog2(N_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [BIT_WIDTH-1:0] r_buf [N_SAMPLES-1:0];

    state_t               w_stateNext;
    logic [IDX_W-1:0]     w_idxNext;
    logic                 w_loadFrame;
    logic                 w_isLast;

    assign w_isLast = (r_idx == LAST_IDX);

    // Next-state and output decode. The outputs come only from registered
    // state, so recv_rdy and send_val have no combinational dependency on the
    // handshake inputs. The one exception is the back-to-back build, where
    // recv_rdy follows send_rdy on the last word. Reset low forces every
    // output to zero. The reset still takes effect on the next edge.
    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_loadFrame = 1'b0;
        recv_rdy    = 1'b0;
        send_val    = 1'b0;
        send_msg    = '0;
        send_last   = 1'b0;

        case (r_state)
            IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    w_loadFrame = 1'b1;
                    w_idxNext   = '0;
                    w_stateNext = SEND;
                end
            end

            SEND: begin
                send_val  = 1'b1;
                send_msg  = r_buf[r_idx];
                send_last = w_isLast;
`ifdef SERIALIZER_BACK_TO_BACK_EN
                if (w_isLast) begin
                    recv_rdy = send_rdy;
                end
`endif
                if (send_rdy) begin
                    if (w_isLast) begin
                        w_idxNext   = '0;
                        w_stateNext = IDLE;
`ifdef SERIALIZER_BACK_TO_BACK_EN
                        // The next frame takes over the buffer on the same
                        // edge that hands off the final word.
                        if (recv_val) begin
                            w_loadFrame = 1'b1;
                            w_stateNext = SEND;
                        end
`endif
                    end else begin
                        w_idxNext = r_idx + 1'b1;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
                w_idxNext   = '0;
            end
        endcase

        if (!reset) begin
            recv_rdy  = 1'b0;
            send_val  = 1'b0;
            send_msg  = '0;
            send_last = 1'b0;
        end
    end

    // State, index and frame buffer. The buffer is written only when a frame
    // is accepted. A reset discards any frame that is still in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            if (w_loadFrame) begin
                r_buf <= recv_msg;
            end
        end
    end

endmodule
